// File: rtl/mac_dot_sequencer.sv
// Feeds cfg_len (data, weight) pairs into one MAC lane and returns the dot product on a valid/ready port.
// res_valid rises on the second edge after the last accept; no operands accepted while a result is held.
module mac_dot_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 32,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic                    abort,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [WEIGHT_WIDTH-1:0] in_weight,
  output logic                    mac_enable,
  output logic                    mac_clear,
  output logic [DATA_WIDTH-1:0]   mac_data,
  output logic [WEIGHT_WIDTH-1:0] mac_weight,
  input  logic [ACCUM_WIDTH-1:0]  mac_accum,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACCUM_WIDTH-1:0]  res_data
);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_HOLD} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] last_idx;
  logic                 feed;
  logic                 accept;

  assign feed     = (state == S_FEED);
  assign last_idx = len - LEN_WIDTH'(1);
  // abort masks the handshake so the producer never sees a beat the MAC did not take
  assign in_ready   = feed & ~abort;
  assign accept     = in_ready & in_valid;
  assign mac_enable = accept;
  assign mac_clear  = accept & (count == '0);
  assign mac_data   = feed ? in_data : '0;
  assign mac_weight = feed ? in_weight : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      len       <= '0;
      count     <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (cfg_len != '0) begin
              len   <= cfg_len;
              count <= '0;
              state <= S_FEED;
            end else begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= S_HOLD;
            end
          end
        end
        S_FEED: begin
          if (in_valid) begin
            count <= count + LEN_WIDTH'(1);
            if (count == last_idx) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // MAC registered the final product on the previous edge
          res_data  <= mac_accum;
          res_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer paired with a behavioural MAC lane; results checked via a scoreboard queue.
module tb_mac_dot_sequencer;

  localparam int DW = 16;
  localparam int WW = 8;
  localparam int AW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [WW-1:0] in_weight = '0;
  logic          mac_enable;
  logic          mac_clear;
  logic [DW-1:0] mac_data;
  logic [WW-1:0] mac_weight;
  logic [AW-1:0] mac_accum;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [AW-1:0] res_data;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int got = 0;
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mac_dot_sequencer #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACCUM_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .abort(abort),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_weight(in_weight), .mac_enable(mac_enable), .mac_clear(mac_clear),
    .mac_data(mac_data), .mac_weight(mac_weight), .mac_accum(mac_accum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // behavioural stand-in for mac_unit_basic: registers one edge after enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_accum <= '0;
    else if (mac_enable)
      mac_accum <= (mac_clear ? '0 : mac_accum) + AW'($signed(mac_data)) * AW'($signed(mac_weight));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mac_enable) en_cnt++;
    if (mac_enable && mac_clear) clr_cnt++;
  end

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready && !abort) begin
      got++;
      if (exp_q.size() == 0) chk("unexpected_result", 64'(res_data), 64'hDEAD);
      else chk("res_data", 64'(res_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dot(input int len);
    start = 1'b1;
    cfg_len = LW'(len);
    step();
    start = 1'b0;
  endtask

  // presents one pair after `gap` idle cycles; returns once the accepting edge has passed
  task automatic send(input logic [DW-1:0] d, input logic [WW-1:0] w, input int gap,
                      input int clr_exp);
    in_valid = 1'b0;
    repeat (gap) begin
      #1;
      chk("bubble_enable", 64'(mac_enable), 64'd0);
      step();
    end
    in_valid = 1'b1;
    in_data = d;
    in_weight = w;
    #1;
    if (clr_exp >= 0) chk("mac_clear", 64'(mac_clear), 64'(clr_exp));
    for (int i = 0; i < 20 && !in_ready; i++) step();
    chk("in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  // counts edges from the accepting edge (inclusive) until res_valid is seen
  task automatic wait_res(output int lat);
    lat = 1;
    for (int i = 0; i < 20 && !res_valid; i++) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #20000000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int en0;
    int clr0;
    logic [AW-1:0] held;

    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mac_enable", 64'(mac_enable), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // 3-beat back-to-back, latency and handshake timing
    en0 = en_cnt; clr0 = clr_cnt;
    exp_q.push_back(32'd43);
    start_dot(3);
    chk("busy_feed", 64'(busy), 64'd1);
    send(16'd5, 8'd3, 0, 1);
    send(16'd2, 8'd4, 0, 0);
    send(16'd10, 8'd2, 0, 0);
    chk("wait_res_valid", 64'(res_valid), 64'd0);
    chk("wait_in_ready", 64'(in_ready), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
    wait_res(lat);
    chk("latency", 64'(lat), 64'd2);
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("en_count_3", 64'(en_cnt - en0), 64'd3);
    chk("clr_count_3", 64'(clr_cnt - clr0), 64'd1);

    // negative operands
    clr0 = clr_cnt;
    exp_q.push_back(32'hFFFFFFE8);
    start_dot(2);
    send(16'd6, 8'hFE, 0, 1);
    send(16'hFFFD, 8'd4, 0, 0);
    wait_res(lat);
    step();
    chk("clr_count_neg", 64'(clr_cnt - clr0), 64'd1);

    // bubbles between beats
    en0 = en_cnt;
    exp_q.push_back(32'd43);
    start_dot(3);
    send(16'd5, 8'd3, 2, 1);
    send(16'd2, 8'd4, 2, 0);
    send(16'd10, 8'd2, 2, 0);
    wait_res(lat);
    chk("latency_gap", 64'(lat), 64'd2);
    step();
    chk("en_count_gap", 64'(en_cnt - en0), 64'd3);

    // result held under backpressure, start ignored
    res_ready = 1'b0;
    exp_q.push_back(32'd9);
    start_dot(1);
    send(16'd3, 8'd3, 0, 1);
    wait_res(lat);
    held = res_data;
    chk("hold_data", 64'(held), 64'd9);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      cfg_len = 8'd2;
      step();
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_stable", 64'(res_data), 64'd9);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    start = 1'b0;
    res_ready = 1'b1;
    step();
    chk("hold_release_busy", 64'(busy), 64'd0);
    chk("hold_release_valid", 64'(res_valid), 64'd0);

    // empty dot product
    en0 = en_cnt;
    exp_q.push_back(32'd0);
    start_dot(0);
    chk("len0_valid", 64'(res_valid), 64'd1);
    step();
    chk("len0_idle", 64'(busy), 64'd0);
    chk("len0_no_enable", 64'(en_cnt - en0), 64'd0);

    // abort mid-product, concurrent with a presented beat
    start_dot(3);
    send(16'd5, 8'd3, 0, 1);
    in_valid = 1'b1;
    in_data = 16'd2;
    in_weight = 8'd4;
    abort = 1'b1;
    #1;
    chk("abort_enable", 64'(mac_enable), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    exp_q.push_back(32'd21);
    start_dot(1);
    send(16'd7, 8'd3, 0, 1);
    wait_res(lat);
    step();

    // maximum length: counter must reach the last element without wrapping
    en0 = en_cnt;
    exp_q.push_back(32'd255);
    start_dot(255);
    for (int i = 0; i < 255; i++) send(16'd1, 8'd1, 0, -1);
    wait_res(lat);
    chk("max_latency", 64'(lat), 64'd2);
    step();
    chk("max_en_count", 64'(en_cnt - en0), 64'd255);

    repeat (2) step();
    chk("results_received", 64'(got), 64'd7);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
